// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, drives the combinational imem address and
// registers each returned word into a single-entry valid/ready stage for decode.
//
// state  | meaning
// -------+----------------------------------------------------------------
// RUN    | fetching sequentially; loads whenever the output stage can accept
// FAULT  | bad PC reported; no further loads until a redirect arrives
module instr_fetch #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0004,
   parameter logic [31:0] IMEM_SIZE = 32'h0000_0900
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic [31:0] imem_address,
   input  logic [31:0] imem_instruction,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instruction,
   output logic [31:0] out_pc,
   output logic [31:0] out_pc_plus4,
   output logic        out_fault,
   output logic [31:0] fetch_count
);

   localparam logic [0:0] ST_RUN   = 1'b0;
   localparam logic [0:0] ST_FAULT = 1'b1;

   logic [0:0]  state;
   logic [31:0] pc;
   logic [31:0] pc_next4;
   logic [31:0] pc_offset;
   logic        pc_bad;
   logic        load;
   logic        handshake;

   assign imem_address = pc;
   assign pc_next4     = pc + 32'd4;
   assign pc_offset    = pc - RESET_PC;

   // Offset compare is unsigned, so a wrapped PC below RESET_PC is caught twice.
   assign pc_bad    = (pc[1:0] != 2'b00) || (pc < RESET_PC) || (pc_offset >= IMEM_SIZE);
   assign handshake = out_valid && out_ready;
   assign load      = (state == ST_RUN) && (!out_valid || out_ready) && !redirect_valid;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state           <= ST_RUN;
         pc              <= RESET_PC;
         out_valid       <= 1'b0;
         out_instruction <= 32'd0;
         out_pc          <= 32'd0;
         out_pc_plus4    <= 32'd0;
         out_fault       <= 1'b0;
         fetch_count     <= 32'd0;
      end else begin
         // Counting is independent of redirect: the consumer already took the entry.
         if (handshake && !out_fault) begin
            fetch_count <= fetch_count + 32'd1;
         end

         if (redirect_valid) begin
            pc        <= redirect_pc;
            out_valid <= 1'b0;
            state     <= ST_RUN;
         end else if (load) begin
            out_valid    <= 1'b1;
            out_pc       <= pc;
            out_pc_plus4 <= pc_next4;
            if (pc_bad) begin
               out_instruction <= 32'd0;
               out_fault       <= 1'b1;
               state           <= ST_FAULT;
            end else begin
               out_instruction <= imem_instruction;
               out_fault       <= 1'b0;
               pc              <= pc_next4;
            end
         end else if (handshake) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
